// File: rtl/fp_pkg.sv
// Shared types and format helpers for the sequential floating-point adder.
// Format helpers take the field widths so any EXP_W/MAN_W pair works.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBNORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } op_class_t;

  function automatic int fpWidth(input int expW, input int manW);
    return 1 + expW + manW;
  endfunction

  function automatic int fpBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  function automatic int fpExpMax(input int expW);
    return (1 << expW) - 1;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the top fraction bit set.
  function automatic logic [127:0] fpQnan(input int expW, input int manW);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < expW; i++) r[manW + i] = 1'b1;
    r[manW - 1] = 1'b1;
    return r;
  endfunction

  function automatic op_class_t classify(input logic expZero, input logic expOnes,
                                         input logic fracZero);
    if (expOnes) return fracZero ? CLS_INF : CLS_NAN;
    if (expZero) return fracZero ? CLS_ZERO : CLS_SUBNORM;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_adder_seq_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter  int WIDTH = 11,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [CW-1:0]    count_o
);

  // Later (higher) set bits override earlier ones, so the MSB-most one wins.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_adder_seq.sv
// Multi-cycle IEEE-754-style add/subtract with round-to-nearest-even,
// one operation in flight, valid/ready handshake on both sides.
module fp_adder_seq
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 7,
  localparam int W     = fpWidth(EXP_W, MAN_W)
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_inexact
);

  localparam int SW = MAN_W + 4;            // hidden + fraction + guard/round/sticky
  localparam int EW = EXP_W + 1;            // headroom for carry and rounding increments
  localparam int CW = $clog2(SW + 1);
  localparam logic [W-1:0]  QNAN    = W'(fpQnan(EXP_W, MAN_W));
  localparam logic [EW-1:0] EXP_MAX = EW'(fpExpMax(EXP_W));

  state_t          state_q, state_d;
  logic [W-1:0]    opA_q, opB_q;
  logic            sign_q, effSub_q, special_q, specInvalid_q, zero_q;
  logic [EW-1:0]   exp_q, normExp_q;
  logic [SW-1:0]   bigSig_q, smallSig_q, normSig_q;
  logic [W-1:0]    specialVal_q, sum_q;
  logic [SW:0]     add_q;
  logic            invalid_q, overflow_q, inexact_q;

  logic            sA, sB;
  logic [EXP_W-1:0] eA, eB, bigE, smallE, bigEff, smallEff, diff;
  logic [MAN_W-1:0] fA, fB, bigF, smallF;
  op_class_t       clsA, clsB;
  logic            aBig, sign_d, special_d, specInvalid_d;
  logic [W-1:0]    specialVal_d;
  logic [SW-1:0]   bigSig_d, smallExt, smallSig_d;

  assign {sA, eA, fA} = opA_q;
  assign {sB, eB, fB} = opB_q;
  assign clsA = classify(eA == '0, &eA, fA == '0);
  assign clsB = classify(eB == '0, &eB, fB == '0);
  assign aBig = opA_q[W-2:0] >= opB_q[W-2:0];

  // Order by magnitude and align the smaller significand, folding lost bits into sticky.
  always_comb begin
    bigE       = aBig ? eA : eB;
    bigF       = aBig ? fA : fB;
    smallE     = aBig ? eB : eA;
    smallF     = aBig ? fB : fA;
    sign_d     = aBig ? sA : sB;
    bigEff     = (bigE == '0) ? EXP_W'(1) : bigE;
    smallEff   = (smallE == '0) ? EXP_W'(1) : smallE;
    diff       = bigEff - smallEff;
    bigSig_d   = {bigE != '0, bigF, 3'b000};
    smallExt   = {smallE != '0, smallF, 3'b000};
    smallSig_d = '0;
    if (32'(diff) >= 32'(SW)) begin
      smallSig_d[0] = |smallExt;
    end else begin
      smallSig_d    = smallExt >> diff;
      smallSig_d[0] = smallSig_d[0] | (|(smallExt & ~({SW{1'b1}} << diff)));
    end
  end

  // Specials and zero operands bypass the arithmetic path with a fixed result.
  always_comb begin
    special_d     = 1'b1;
    specInvalid_d = 1'b0;
    specialVal_d  = '0;
    if (clsA == CLS_NAN || clsB == CLS_NAN) begin
      specialVal_d = QNAN;
    end else if (clsA == CLS_INF && clsB == CLS_INF) begin
      specialVal_d  = (sA != sB) ? QNAN : opA_q;
      specInvalid_d = sA != sB;
    end else if (clsA == CLS_INF) begin
      specialVal_d = opA_q;
    end else if (clsB == CLS_INF) begin
      specialVal_d = opB_q;
    end else if (clsA == CLS_ZERO && clsB == CLS_ZERO) begin
      specialVal_d = {sA & sB, {(W-1){1'b0}}};
    end else if (clsB == CLS_ZERO) begin
      specialVal_d = opA_q;
    end else if (clsA == CLS_ZERO) begin
      specialVal_d = opB_q;
    end else begin
      special_d = 1'b0;
    end
  end

  logic [SW:0]    add_d;
  logic [CW-1:0]  lzCount;
  logic [31:0]    shiftAmt;
  logic [SW-1:0]  normSig_d;
  logic [EW-1:0]  normExp_d;
  logic           zero_d;

  assign add_d = effSub_q ? ({1'b0, bigSig_q} - {1'b0, smallSig_q})
                          : ({1'b0, bigSig_q} + {1'b0, smallSig_q});

  fp_lzc #(.WIDTH(SW)) uLzc (
    .value_i (add_q[SW-1:0]),
    .count_o (lzCount)
  );

  // Left shifts stop at exponent 1; a limited shift leaves a subnormal (stored exp 0).
  always_comb begin
    normSig_d = '0;
    normExp_d = exp_q;
    zero_d    = 1'b0;
    shiftAmt  = '0;
    if (add_q[SW]) begin
      normSig_d    = add_q[SW:1];
      normSig_d[0] = add_q[1] | add_q[0];
      normExp_d    = exp_q + EW'(1);
    end else if (add_q[SW-1:0] == '0) begin
      zero_d = 1'b1;
    end else begin
      shiftAmt  = (32'(lzCount) < 32'(exp_q) - 32'd1) ? 32'(lzCount) : 32'(exp_q) - 32'd1;
      normSig_d = add_q[SW-1:0] << shiftAmt;
      normExp_d = normSig_d[SW-1] ? exp_q - EW'(shiftAmt) : '0;
    end
  end

  logic           roundUp, overflow_d, inexact_d, invalid_d;
  logic [MAN_W+1:0] mantRnd;
  logic [EW-1:0]  expRnd;
  logic [MAN_W-1:0] fracRnd;
  logic [W-1:0]   result_d;

  always_comb begin
    roundUp = normSig_q[2] & (normSig_q[1] | normSig_q[0] | normSig_q[3]);
    mantRnd = {1'b0, normSig_q[SW-1:3]} + (MAN_W+2)'(roundUp);
    expRnd  = normExp_q;
    fracRnd = mantRnd[MAN_W-1:0];
    if (mantRnd[MAN_W+1]) begin
      expRnd  = normExp_q + EW'(1);
      fracRnd = mantRnd[MAN_W:1];
    end else if (normExp_q == '0 && mantRnd[MAN_W]) begin
      expRnd = EW'(1);
    end
    result_d   = {sign_q, expRnd[EXP_W-1:0], fracRnd};
    overflow_d = 1'b0;
    invalid_d  = 1'b0;
    inexact_d  = |normSig_q[2:0];
    if (special_q) begin
      result_d  = specialVal_q;
      invalid_d = specInvalid_q;
      inexact_d = 1'b0;
    end else if (zero_q) begin
      result_d  = '0;
      inexact_d = 1'b0;
    end else if (expRnd >= EXP_MAX) begin
      result_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= ST_IDLE;
      opA_q         <= '0;
      opB_q         <= '0;
      sign_q        <= 1'b0;
      effSub_q      <= 1'b0;
      exp_q         <= '0;
      bigSig_q      <= '0;
      smallSig_q    <= '0;
      special_q     <= 1'b0;
      specInvalid_q <= 1'b0;
      specialVal_q  <= '0;
      add_q         <= '0;
      normSig_q     <= '0;
      normExp_q     <= '0;
      zero_q        <= 1'b0;
      sum_q         <= '0;
      invalid_q     <= 1'b0;
      overflow_q    <= 1'b0;
      inexact_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          opA_q      <= a;
          opB_q      <= {b[W-1] ^ sub, b[W-2:0]};
          invalid_q  <= 1'b0;
          overflow_q <= 1'b0;
          inexact_q  <= 1'b0;
        end
        ST_ALIGN: begin
          sign_q        <= sign_d;
          effSub_q      <= sA ^ sB;
          exp_q         <= EW'(bigEff);
          bigSig_q      <= bigSig_d;
          smallSig_q    <= smallSig_d;
          special_q     <= special_d;
          specInvalid_q <= specInvalid_d;
          specialVal_q  <= specialVal_d;
        end
        ST_ADD: add_q <= add_d;
        ST_NORM: begin
          normSig_q <= normSig_d;
          normExp_q <= normExp_d;
          zero_q    <= zero_d;
        end
        ST_ROUND: begin
          sum_q      <= result_d;
          invalid_q  <= invalid_d;
          overflow_q <= overflow_d;
          inexact_q  <= inexact_d;
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = state_q == ST_IDLE;
  assign out_valid     = state_q == ST_DONE;
  assign sum           = sum_q;
  assign flag_invalid  = invalid_q;
  assign flag_overflow = overflow_q;
  assign flag_inexact  = inexact_q;

endmodule

// File: tb/tb_fp_adder_seq.sv
// Self-checking bench for fp_adder_seq (bfloat16): directed cases, handshake,
// mid-operation reset, and random operands against an exact-arithmetic model.
module tb_fp_adder_seq;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid;
  logic [15:0] sum;
  logic        flag_invalid, flag_overflow, flag_inexact;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  fp_adder_seq dut (
    .clock         (clock),
    .n_reset       (n_reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .sub           (sub),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sum           (sum),
    .flag_invalid  (flag_invalid),
    .flag_overflow (flag_overflow),
    .flag_inexact  (flag_inexact)
  );

  typedef struct packed {
    logic [15:0] opA;
    logic [15:0] opB;
    logic        opSub;
    logic [15:0] expSum;
    logic [2:0]  expFlags;
  } vec_t;

  // Expected flags are ordered {invalid, overflow, inexact}.
  vec_t dirVecs [0:17] = '{
    {16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000},
    {16'h4040, 16'h3F80, 1'b1, 16'h4000, 3'b000},
    {16'h3F80, 16'hBF80, 1'b0, 16'h0000, 3'b000},
    {16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 3'b001},
    {16'h3F80, 16'h3C40, 1'b0, 16'h3F82, 3'b001},
    {16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 3'b011},
    {16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 3'b100},
    {16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b000},
    {16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000},
    {16'h0040, 16'h0040, 1'b0, 16'h0080, 3'b000},
    {16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000},
    {16'h0005, 16'h0000, 1'b0, 16'h0005, 3'b000},
    {16'h0000, 16'h8005, 1'b1, 16'h0005, 3'b000},
    {16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b100},
    {16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 3'b000},
    {16'h3F80, 16'h3F80, 1'b1, 16'h0000, 3'b000},
    {16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b000},
    {16'hC000, 16'h3F80, 1'b0, 16'hBF80, 3'b000}
  };

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Exact sum on a wide integer grid, then a single rounding to bfloat16.
  function automatic void refModel(input logic [15:0] x, input logic [15:0] y,
                                   input logic subOp, output logic [15:0] res,
                                   output logic [2:0] flg);
    logic        sx, sy, sr;
    int          ex, ey, fx, fy, p, k, keep, e;
    logic [279:0] vx, vy, mag, rem, half, sh;
    sx = x[15]; sy = y[15] ^ subOp;
    ex = int'(x[14:7]); ey = int'(y[14:7]);
    fx = int'(x[6:0]);  fy = int'(y[6:0]);
    res = '0; flg = '0;
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) begin
      res = 16'h7FC0; return;
    end
    if (ex == 255 && ey == 255) begin
      if (sx != sy) begin res = 16'h7FC0; flg = 3'b100; end
      else res = {sx, 15'h7F80};
      return;
    end
    if (ex == 255) begin res = {sx, 15'h7F80}; return; end
    if (ey == 255) begin res = {sy, 15'h7F80}; return; end
    vx = 280'(ex == 0 ? fx : fx + 128) << (ex == 0 ? 0 : ex - 1);
    vy = 280'(ey == 0 ? fy : fy + 128) << (ey == 0 ? 0 : ey - 1);
    if (sx == sy) begin mag = vx + vy; sr = sx; end
    else if (vx >= vy) begin mag = vx - vy; sr = sx; end
    else begin mag = vy - vx; sr = sy; end
    if (mag == '0) begin
      res = {(vx == '0 && vy == '0) ? (sx & sy) : 1'b0, 15'h0};
      return;
    end
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p < 8) begin res = {sr, mag[14:0]}; return; end
    k    = p - 7;
    sh   = mag >> k;
    keep = int'(sh[31:0]);
    rem  = mag & ((280'(1) << k) - 280'(1));
    half = 280'(1) << (k - 1);
    if (rem > half || (rem == half && keep % 2 == 1)) keep++;
    if (keep == 256) begin keep = 128; k++; end
    e = k + 1;
    if (e >= 255) begin
      res = {sr, 15'h7F80}; flg = 3'b011;
    end else begin
      res = {sr, 8'(e), 7'(keep)};
      flg = {2'b00, rem != '0};
    end
  endfunction

  function automatic logic [15:0] genOperand(input logic [15:0] near, input logic useNear);
    int         kind, e;
    logic [6:0] f;
    logic       s;
    kind = int'($urandom_range(0, 19));
    s    = 1'($urandom_range(0, 1));
    f    = 7'($urandom);
    if (useNear && kind == 7) return {s, near[14:0]};
    if (kind == 0) begin e = 0; f = 7'h0; end
    else if (kind <= 2) e = 0;
    else if (kind == 3) begin e = 255; f = 7'h0; end
    else if (kind == 4) begin e = 255; f = f | 7'h1; end
    else if (kind <= 6) e = int'($urandom_range(250, 254));
    else if (useNear) begin
      e = int'(near[14:7]) + int'($urandom_range(0, 6)) - 3;
      if (e < 0) e = 0;
      if (e > 254) e = 254;
    end else e = int'($urandom_range(1, 254));
    return {s, 8'(e), f};
  endfunction

  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                               input logic opSub);
    int edges;
    checkValue("ready before accept", in_ready, 1);
    a = opA; b = opB; sub = opSub; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clock); #1;
      edges++;
    end
    checkValue("latency", edges, 4);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expSum,
                             input logic [2:0] expFlags);
    checkValue({tag, " sum"}, sum, expSum);
    checkValue({tag, " flags"}, {flag_invalid, flag_overflow, flag_inexact}, expFlags);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkValue({tag, " release"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] opA, opB, expSum;
    logic [2:0]  expFlags;
    logic        opSub;

    #2;
    checkValue("reset ready/valid", {in_ready, out_valid}, 2'b10);
    checkValue("reset sum", sum, 0);
    checkValue("reset flags", {flag_invalid, flag_overflow, flag_inexact}, 0);
    @(posedge clock); #1;
    n_reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(dirVecs[i].opA, dirVecs[i].opB, dirVecs[i].opSub);
      checkOutput($sformatf("dir%0d", i), dirVecs[i].expSum, dirVecs[i].expFlags);
    end

    applyStimulus(16'h3F80, 16'h3F80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checkValue("hold sum", sum, 16'h4000);
      checkValue("hold flags", {flag_invalid, flag_overflow, flag_inexact}, 0);
      checkValue("hold ready/valid", {in_ready, out_valid}, 2'b01);
    end
    a = 16'h4040; b = 16'h4040; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkValue("no accept on release", {in_ready, out_valid}, 2'b10);

    a = 16'h3F80; b = 16'h4040; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    n_reset = 1'b0;
    #1;
    checkValue("abort ready/valid", {in_ready, out_valid}, 2'b10);
    checkValue("abort sum", sum, 0);
    @(posedge clock); #1;
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      checkValue("abort no result", {in_ready, out_valid}, 2'b10);
    end

    for (int n = 0; n < 300; n++) begin
      opA   = genOperand(16'h0, 1'b0);
      opB   = genOperand(opA, $urandom_range(0, 1) == 1);
      opSub = 1'($urandom_range(0, 1));
      refModel(opA, opB, opSub, expSum, expFlags);
      applyStimulus(opA, opB, opSub);
      checkOutput($sformatf("rnd%0d %h%s%h", n, opA, opSub ? "-" : "+", opB),
                  expSum, expFlags);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
